// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-loadable N-bit serial pattern detector with a saturating match counter
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   x          serial data bit, sampled only when x_valid is high
//   x_valid    qualifies x; low cycles are transparent gaps
//   overlap    1 = overlapping matches, 0 = next match needs N fresh bits
//   pat_in     new pattern, pat_in[N-1] is the first bit expected
//   pat_load   loads pat_in, discards this edge's sample and restarts the fill
//   cnt_clr    synchronous clear of match_cnt (wins over an increment)
//   detect     registered one-cycle match pulse
//   match_cnt  saturating number of matches
module seq_detect_param #(
   parameter int             N         = 4,
   parameter logic [N-1:0]   RESET_PAT = 4'b1011,
   parameter int             CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             x,
   input  logic             x_valid,
   input  logic             overlap,
   input  logic [N-1:0]     pat_in,
   input  logic             pat_load,
   input  logic             cnt_clr,
   output logic             detect,
   output logic [CNT_W-1:0] match_cnt
);
   localparam int           FW   = $clog2(N + 1);
   localparam logic [FW-1:0] FULL = FW'(N);
   localparam logic [FW-1:0] NEED = FW'(N - 1);
   logic [N-1:0]  pat;
   logic [N-2:0]  hist;
   logic [FW-1:0] fill;
   logic [N-1:0]  cand;
   logic          match;
   always_comb begin
      cand  = {hist, x};
      match = x_valid && !pat_load && fill >= NEED && cand == pat;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         pat       <= RESET_PAT;
         hist      <= '0;
         fill      <= '0;
         detect    <= 1'b0;
         match_cnt <= '0;
      end else begin
         detect    <= match;
         match_cnt <= cnt_clr ? '0 : (match && match_cnt != '1) ? match_cnt + 1'b1 : match_cnt;
         if (pat_load) begin
            pat  <= pat_in;
            fill <= '0;
         end else if (x_valid) begin
            hist <= cand[N-2:0];
            // a non-overlapping match consumes its bits, so the fill restarts
            fill <= (match && !overlap) ? '0 : (fill == FULL) ? fill : fill + 1'b1;
         end
      end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed and random checks of seq_detect_param against a queue-based model
module tb_seq_detect_param;
   localparam int N = 4;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         x = 1'b0, x_valid = 1'b0, overlap = 1'b1, pat_load = 1'b0, cnt_clr = 1'b0;
   logic [N-1:0] pat_in = '0;
   logic         detect, detect2;
   logic [7:0]   cnt8;
   logic [1:0]   cnt2;
   int           errors = 0, checks = 0;
   logic         ov = 1'b1;
   // model: every valid bit since reset, index where usable bits begin, current pattern, counts
   logic         bits[$];
   int           start = 0;
   logic [N-1:0] pat_m = 4'b1011;
   int           exp8 = 0, exp2 = 0;
   logic         exp_det = 1'b0;

   seq_detect_param dut (.clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap),
      .pat_in(pat_in), .pat_load(pat_load), .cnt_clr(cnt_clr), .detect(detect), .match_cnt(cnt8));
   seq_detect_param #(.CNT_W(2)) dut2 (.clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid),
      .overlap(overlap), .pat_in(pat_in), .pat_load(pat_load), .cnt_clr(cnt_clr), .detect(detect2),
      .match_cnt(cnt2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_det"}, int'(detect), int'(exp_det));
      chk({tag, "_det2"}, int'(detect2), int'(exp_det));
      chk({tag, "_cnt8"}, int'(cnt8), exp8);
      chk({tag, "_cnt2"}, int'(cnt2), exp2);
   endtask

   task automatic step(input logic xi, vi, ovi, ldi, input logic [N-1:0] pi, input logic clr);
      logic [N-1:0] w;
      logic         m;
      x = xi; x_valid = vi; overlap = ovi; pat_load = ldi; pat_in = pi; cnt_clr = clr;
      w = '0;
      m = 1'b0;
      if (bits.size() - start >= N - 1) begin
         for (int i = N - 2; i >= 0; i--) w = {w[N-2:0], bits[bits.size() - 1 - i]};
         w = {w[N-2:0], xi};
         m = vi && !ldi && w == pat_m;
      end
      exp_det = m;
      exp8 = clr ? 0 : (m && exp8 < 255) ? exp8 + 1 : exp8;
      exp2 = clr ? 0 : (m && exp2 < 3) ? exp2 + 1 : exp2;
      if (ldi) begin
         pat_m = pi;
         start = bits.size();
      end else if (vi) begin
         bits.push_back(xi);
         if (m && !ovi) start = bits.size();
      end
      @(posedge clk);
      #1;
      chk_all("step");
   endtask

   task automatic vbit(input logic b);
      step(b, 1'b1, ov, 1'b0, '0, 1'b0);
   endtask

   task automatic gap();
      step(1'($urandom), 1'b0, ov, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      #1 reset_n = 1'b0;
      #1;
      bits.delete();
      start = 0; pat_m = 4'b1011; exp8 = 0; exp2 = 0; exp_det = 1'b0;
      chk_all("reset");
      #1 reset_n = 1'b1;
   endtask

   initial begin
      logic [6:0] s1;
      s1 = 7'b1011011;
      @(posedge clk);
      #1;
      do_reset();
      // overlapping stream 1011011
      ov = 1'b1;
      for (int i = 6; i >= 0; i--) vbit(s1[i]);
      chk("ovl_cnt", int'(cnt8), 2);
      do_reset();
      ov = 1'b0;
      for (int i = 6; i >= 0; i--) vbit(s1[i]);
      chk("novl_cnt", int'(cnt8), 1);
      // gaps between valid bits
      do_reset();
      ov = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         vbit(s1[i + 3]);
         if (i != 0) repeat (3) gap();
      end
      chk("gap_det", int'(detect), 1);
      chk("gap_cnt", int'(cnt8), 1);
      // all-zero pattern, overlapping then non-overlapping
      for (int o = 1; o >= 0; o--) begin
         do_reset();
         ov = 1'(o);
         step(1'b1, 1'b1, ov, 1'b1, 4'b0000, 1'b0);
         repeat (6) vbit(1'b0);
         chk("zero_cnt", int'(cnt8), o ? 3 : 1);
      end
      // saturation of the narrow counter, then clear colliding with a match
      do_reset();
      ov = 1'b0;
      repeat (5) for (int i = 3; i >= 0; i--) vbit(s1[i + 3]);
      chk("sat_cnt2", int'(cnt2), 3);
      chk("sat_cnt8", int'(cnt8), 5);
      vbit(1'b1); vbit(1'b0); vbit(1'b1);
      step(1'b1, 1'b1, ov, 1'b0, '0, 1'b1);
      chk("clr_det", int'(detect2), 1);
      chk("clr_cnt2", int'(cnt2), 0);
      // reset mid-sequence reverts a loaded pattern
      do_reset();
      ov = 1'b1;
      step(1'b0, 1'b1, ov, 1'b1, 4'b0110, 1'b0);
      vbit(1'b1); vbit(1'b0); vbit(1'b1); vbit(1'b1); vbit(1'b0);
      chk("pre_rst_det", int'(detect), 1);
      do_reset();
      vbit(1'b1);
      chk("post_rst_det", int'(detect), 0);
      vbit(1'b1); vbit(1'b0); vbit(1'b1); vbit(1'b1);
      chk("revert_det", int'(detect), 1);
      // randomized traffic
      do_reset();
      for (int i = 0; i < 600; i++)
         step(1'($urandom), ($urandom % 4) != 0, 1'($urandom), ($urandom % 20) == 0,
              N'($urandom), ($urandom % 25) == 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
